conv_enc_ctrl: RTL

Sequencing controller for the convolutional encoder datapath. It takes a start command and either streams one frame of information bits into the encoder in encode mode, or sweeps every (state, input-pair) combination for the radix-4 branch table in decode mode. It generates the encoder's enable, mode, input-bit and sweep-index controls, and reports busy, output-valid and done status to the top-level controller.

---
 rtl/conv_enc_ctrl_if.sv | 37 +++
 rtl/conv_enc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_ctrl_if.sv
// conv_enc_ctrl_if: command, bit-stream and encoder-control signals of conv_enc_ctrl.
// master = top-level controller / bit source side, slave = conv_enc_ctrl.
interface conv_enc_ctrl_if;
    localparam int unsigned STATE_W = 8;
    localparam int unsigned PAIR_W  = 2;
    localparam int unsigned FLEN_W  = 16;

    logic                i_start;
    logic                i_mode_sel;
    logic [1:0]          i_constr_len;
    logic [FLEN_W-1:0]   i_frame_len;
    logic                i_bit_valid;
    logic                i_bit;

    logic                o_bit_ready;
    logic                o_en_ce;
    logic                o_mode_sel;
    logic                o_encoder_bit;
    logic [STATE_W-1:0]  o_state_idx;
    logic [PAIR_W-1:0]   o_pair_idx;
    logic                o_tail;
    logic                o_out_valid;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_start, i_mode_sel, i_constr_len, i_frame_len, i_bit_valid, i_bit,
        input  o_bit_ready, o_en_ce, o_mode_sel, o_encoder_bit, o_state_idx,
               o_pair_idx, o_tail, o_out_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_mode_sel, i_constr_len, i_frame_len, i_bit_valid, i_bit,
        output o_bit_ready, o_en_ce, o_mode_sel, o_encoder_bit, o_state_idx,
               o_pair_idx, o_tail, o_out_valid, o_busy, o_done
    );
endinterface

// File: rtl/conv_enc_ctrl.sv
// conv_enc_ctrl: sequences one encode frame or one radix-4 branch-table sweep for the encoder.
// Optional CONV_TAIL_FLUSH_EN: appends K-1 zero flush bits after each encode frame.
module conv_enc_ctrl (
    input  logic            clk,
    input  logic            rst,
    conv_enc_ctrl_if.slave  bus
);
    localparam int unsigned MAX_CONSTRAINT_LENGTH = 9;
    localparam int unsigned RADIX   = 4;
    localparam int unsigned STATE_W = MAX_CONSTRAINT_LENGTH - 1;
    localparam int unsigned PAIR_W  = $clog2(RADIX);
    localparam int unsigned FLEN_W  = 16;
    localparam int unsigned KM1_W   = 4;
    localparam logic        DECODE_MODE = 1'b1;

    typedef enum logic [2:0] {IDLE, ENC_DATA, ENC_TAIL, SWEEP, DONE} state_e;

    state_e              state_q, state_d;
    logic                mode_sel_q, mode_sel_d;
    logic [KM1_W-1:0]    km1_q, km1_d;
    logic [FLEN_W-1:0]   frame_len_q, frame_len_d;
    logic [FLEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                bit_ready_q, bit_ready_d;
    logic                en_ce_q, en_ce_d;
    logic                encoder_bit_q, encoder_bit_d;
    logic [STATE_W-1:0]  state_idx_q, state_idx_d;
    logic [PAIR_W-1:0]   pair_idx_q, pair_idx_d;
    logic                tail_q, tail_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [STATE_W-1:0]  state_last_c;
    logic                xfer_c;
`ifdef CONV_TAIL_FLUSH_EN
    logic [KM1_W-1:0]    tail_cnt_q, tail_cnt_d;
`endif

    // Highest trellis state for the latched K: 2^(K-1)-1
    assign state_last_c = STATE_W'(((STATE_W+1)'(1) << km1_q) - (STATE_W+1)'(1));
    assign xfer_c       = bit_ready_q & bus.i_bit_valid;

    always_comb begin
        state_d       = state_q;
        mode_sel_d    = mode_sel_q;
        km1_d         = km1_q;
        frame_len_d   = frame_len_q;
        bit_cnt_d     = bit_cnt_q;
        state_idx_d   = state_idx_q;
        pair_idx_d    = pair_idx_q;
        bit_ready_d   = 1'b0;
        en_ce_d       = 1'b0;
        encoder_bit_d = 1'b0;
        tail_d        = 1'b0;
        done_d        = 1'b0;
        out_valid_d   = en_ce_q;
`ifdef CONV_TAIL_FLUSH_EN
        tail_cnt_d    = tail_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    mode_sel_d  = bus.i_mode_sel;
                    km1_d       = KM1_W'({bus.i_constr_len, 1'b0}) + KM1_W'(2);
                    frame_len_d = bus.i_frame_len;
                    bit_cnt_d   = '0;
                    state_idx_d = '0;
                    pair_idx_d  = '0;
`ifdef CONV_TAIL_FLUSH_EN
                    tail_cnt_d  = '0;
`endif
                    if (bus.i_mode_sel == DECODE_MODE) begin
                        // First sweep combination is driven straight out of the accept edge
                        state_d = SWEEP;
                        en_ce_d = 1'b1;
                    end else if (bus.i_frame_len == '0) begin
`ifdef CONV_TAIL_FLUSH_EN
                        state_d = ENC_TAIL;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d     = ENC_DATA;
                        bit_ready_d = 1'b1;
                    end
                end
            end
            ENC_DATA: begin
                bit_ready_d = 1'b1;
                if (xfer_c) begin
                    en_ce_d       = 1'b1;
                    encoder_bit_d = bus.i_bit;
                    bit_cnt_d     = bit_cnt_q + FLEN_W'(1);
                    if (bit_cnt_d == frame_len_q) begin
                        bit_ready_d = 1'b0;
`ifdef CONV_TAIL_FLUSH_EN
                        state_d     = ENC_TAIL;
`else
                        state_d     = DONE;
`endif
                    end
                end
            end
`ifdef CONV_TAIL_FLUSH_EN
            ENC_TAIL: begin
                en_ce_d    = 1'b1;
                tail_d     = 1'b1;
                tail_cnt_d = tail_cnt_q + KM1_W'(1);
                if (tail_cnt_q == km1_q - KM1_W'(1)) begin
                    state_d = DONE;
                end
            end
`endif
            SWEEP: begin
                if (state_idx_q == state_last_c && pair_idx_q == PAIR_W'(RADIX - 1)) begin
                    state_d = DONE;
                end else begin
                    en_ce_d    = 1'b1;
                    pair_idx_d = pair_idx_q + PAIR_W'(1);
                    if (pair_idx_q == PAIR_W'(RADIX - 1)) begin
                        state_idx_d = state_idx_q + STATE_W'(1);
                    end
                end
            end
            DONE: begin
                // Hold off the pulse until the last encoder cycle has produced its output
                if (done_q) begin
                    state_d = IDLE;
                end else if (!en_ce_q) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mode_sel_q    <= 1'b0;
            km1_q         <= '0;
            frame_len_q   <= '0;
            bit_cnt_q     <= '0;
            bit_ready_q   <= 1'b0;
            en_ce_q       <= 1'b0;
            encoder_bit_q <= 1'b0;
            state_idx_q   <= '0;
            pair_idx_q    <= '0;
            tail_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef CONV_TAIL_FLUSH_EN
            tail_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mode_sel_q    <= mode_sel_d;
            km1_q         <= km1_d;
            frame_len_q   <= frame_len_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_ready_q   <= bit_ready_d;
            en_ce_q       <= en_ce_d;
            encoder_bit_q <= encoder_bit_d;
            state_idx_q   <= state_idx_d;
            pair_idx_q    <= pair_idx_d;
            tail_q        <= tail_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef CONV_TAIL_FLUSH_EN
            tail_cnt_q    <= tail_cnt_d;
`endif
        end
    end

    assign bus.o_bit_ready   = bit_ready_q;
    assign bus.o_en_ce       = en_ce_q;
    assign bus.o_mode_sel    = mode_sel_q;
    assign bus.o_encoder_bit = encoder_bit_q;
    assign bus.o_state_idx   = state_idx_q;
    assign bus.o_pair_idx    = pair_idx_q;
    assign bus.o_tail        = tail_q;
    assign bus.o_out_valid   = out_valid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
endmodule
